// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared definitions for the PPU render pipeline: frame geometry, the row
// index width used by the pixel engines, the default watchdog budget and
// the scanline sequencer state type.
// ---------------------------------------------------------------------------
package ppu_pkg;

  // Visible scanlines per frame; row index runs 0..PPU_NUM_ROWS-1.
  localparam int PPU_NUM_ROWS = 240;

  // Row index width shared with the BG/FG/sprite engines.
  localparam int PPU_ROW_W = 8;

  // Cycles allowed from engine_start to pmxr_done before the watchdog fires.
  localparam int PPU_WDOG_CYCLES = 2047;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_RENDER     = 3'd2,
    ST_READY      = 3'd3,
    ST_FRAME_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/up_counter.sv
// ---------------------------------------------------------------------------
// up_counter
// Saturating up-counter with synchronous clear. Clear has priority over
// enable; once the counter reaches all-ones it holds there until cleared.
//
// Ports
//   clk    in   1      clock
//   rst_n  in   1      asynchronous active-low reset
//   clr    in   1      synchronous clear to zero
//   en     in   1      count enable (+1 per cycle)
//   count  out  WIDTH  current count
// ---------------------------------------------------------------------------
module up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ppu_row_sequencer.sv
// ---------------------------------------------------------------------------
// ppu_row_sequencer
// Frame/scanline scheduler for the PPU render pipeline. For each scanline it
// issues a row index and a one-cycle start pulse to the pixel engines, waits
// for the mixer to finish the back rowbuffer, then holds until the display
// side swaps rowbuffers. It also resynchronises on vsync, opens the
// end-of-frame VRAM sync window and reports overrun / watchdog errors.
//
// Ports
//   clk            in   1      system clock
//   rst_n          in   1      asynchronous active-low reset
//   ppu_enable     in   1      level; low forces IDLE and clears sticky flags
//   vsync          in   1      pulse; start of vblank, next rendered row is 0
//   rowram_swap    in   1      pulse; back rowbuffer promoted to front
//   pmxr_done      in   1      pulse; mixer finished the current row
//   render_row     out  ROW_W  row index being rendered
//   engine_start   out  1      one-cycle start pulse to the engines
//   row_ready      out  1      back rowbuffer holds a complete row
//   vram_sync_win  out  1      end-of-frame VRAM sync window
//   overrun        out  1      sticky; swap/vsync arrived before row completed
//   wdog_fired     out  1      sticky; mixer did not finish in time
// ---------------------------------------------------------------------------
module ppu_row_sequencer
  import ppu_pkg::*;
#(
  parameter int NUM_ROWS    = PPU_NUM_ROWS,
  parameter int ROW_W       = PPU_ROW_W,
  parameter int WDOG_CYCLES = PPU_WDOG_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ppu_enable,
  input  logic             vsync,
  input  logic             rowram_swap,
  input  logic             pmxr_done,
  output logic [ROW_W-1:0] render_row,
  output logic             engine_start,
  output logic             row_ready,
  output logic             vram_sync_win,
  output logic             overrun,
  output logic             wdog_fired
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  // The counter reads 0 on the first RENDER cycle, so the edge that moves it
  // from WDOG_CYCLES-2 to WDOG_CYCLES-1 is the expiry edge. That places the
  // READY entry exactly WDOG_CYCLES cycles after the START cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 2);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_d;
  logic             ovr_q;
  logic             ovr_d;
  logic             wd_q;
  logic             wd_d;

  logic              wdog_clr;
  logic              wdog_en;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_expire;

  assign wdog_en  = (state_q == ST_RENDER);
  assign wdog_clr = (state_q != ST_RENDER);

  up_counter #(
    .WIDTH (WDOG_W)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wdog_clr),
    .en    (wdog_en),
    .count (wdog_cnt)
  );

  assign wdog_expire = (wdog_cnt == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ovr_d   = ovr_q;
    wd_d    = wd_q;

    if (!ppu_enable) begin
      // Disable overrides every other input and returns to the reset picture.
      state_d = ST_IDLE;
      row_d   = '0;
      ovr_d   = 1'b0;
      wd_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vsync) begin
            row_d   = '0;
            state_d = ST_START;
          end
        end

        ST_START: begin
          if (vsync) begin
            // Mid-frame vsync: resync to row 0 and flag the lost frame.
            ovr_d   = 1'b1;
            row_d   = '0;
            state_d = ST_START;
          end else begin
            // An early swap is flagged but not remembered.
            if (rowram_swap) begin
              ovr_d = 1'b1;
            end
            state_d = ST_RENDER;
          end
        end

        ST_RENDER: begin
          if (vsync) begin
            ovr_d   = 1'b1;
            row_d   = '0;
            state_d = ST_START;
          end else begin
            if (rowram_swap) begin
              ovr_d = 1'b1;
            end
            // A done on the expiry cycle counts as a normal completion.
            if (pmxr_done) begin
              state_d = ST_READY;
            end else if (wdog_expire) begin
              wd_d    = 1'b1;
              state_d = ST_READY;
            end
          end
        end

        ST_READY: begin
          if (vsync) begin
            ovr_d   = 1'b1;
            row_d   = '0;
            state_d = ST_START;
          end else if (rowram_swap) begin
            if (row_q == LAST_ROW) begin
              state_d = ST_FRAME_DONE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = ST_START;
            end
          end
        end

        ST_FRAME_DONE: begin
          // Regular end of frame: vsync here is expected, not an overrun.
          if (vsync) begin
            row_d   = '0;
            state_d = ST_START;
          end
        end

        default: begin
          state_d = ST_IDLE;
          row_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      ovr_q   <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ovr_q   <= ovr_d;
      wd_q    <= wd_d;
    end
  end

  assign render_row    = row_q;
  assign engine_start  = (state_q == ST_START);
  assign row_ready     = (state_q == ST_READY);
  assign vram_sync_win = (state_q == ST_FRAME_DONE);
  assign overrun       = ovr_q;
  assign wdog_fired    = wd_q;

endmodule

// File: tb/tb_ppu_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ppu_row_sequencer
// Directed bench for ppu_row_sequencer. A scanline-level model tracks the
// current row, which phase of the row is in progress and the sticky flags;
// one process compares every DUT output to it on each falling clock edge,
// while the stimulus process pins key points with hand-computed values.
// Row timing inside a frame is shortened (done@+40 / swap@+80) so a full
// 240-row frame stays well inside the cycle budget.
// ---------------------------------------------------------------------------
module tb_ppu_row_sequencer;

  localparam int NR = 240;
  localparam int RW = 8;
  localparam int WD = 2047;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ppu_enable = 1'b0;
  logic          vsync = 1'b0;
  logic          rowram_swap = 1'b0;
  logic          pmxr_done = 1'b0;
  logic [RW-1:0] render_row;
  logic          engine_start;
  logic          row_ready;
  logic          vram_sync_win;
  logic          overrun;
  logic          wdog_fired;

  int errors = 0;
  int checks = 0;
  int es_count = 0;

  always #5 clk = ~clk;

  ppu_row_sequencer #(
    .NUM_ROWS    (NR),
    .ROW_W       (RW),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ppu_enable    (ppu_enable),
    .vsync         (vsync),
    .rowram_swap   (rowram_swap),
    .pmxr_done     (pmxr_done),
    .render_row    (render_row),
    .engine_start  (engine_start),
    .row_ready     (row_ready),
    .vram_sync_win (vram_sync_win),
    .overrun       (overrun),
    .wdog_fired    (wdog_fired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scanline model ----------------
  int m_row     = 0;
  int m_elapsed = 0;   // RENDER cycles spent on the current row
  bit m_start = 0, m_render = 0, m_ready = 0, m_fdone = 0, m_ovr = 0, m_wd = 0;

  task automatic model_clear();
    m_row = 0; m_elapsed = 0;
    m_start = 0; m_render = 0; m_ready = 0; m_fdone = 0;
    m_ovr = 0; m_wd = 0;
  endtask

  task automatic model_begin_row(input int row);
    m_row = row; m_elapsed = 0;
    m_start = 1; m_render = 0; m_ready = 0; m_fdone = 0;
  endtask

  task automatic model_step(input bit en, input bit vs, input bit sw, input bit dn);
    bit busy;
    busy = m_start | m_render | m_ready | m_fdone;
    if (!en) begin
      model_clear();
    end else if (!busy) begin
      if (vs) model_begin_row(0);
    end else if (vs) begin
      if (!m_fdone) m_ovr = 1;
      model_begin_row(0);
    end else if (m_start) begin
      if (sw) m_ovr = 1;
      m_start = 0; m_render = 1; m_elapsed = 0;
    end else if (m_render) begin
      if (sw) m_ovr = 1;
      m_elapsed++;
      if (dn || m_elapsed == WD - 1) begin
        if (!dn) m_wd = 1;
        m_render = 0; m_ready = 1;
      end
    end else if (m_ready) begin
      if (sw) begin
        if (m_row == NR - 1) begin
          m_ready = 0; m_fdone = 1;
        end else begin
          model_begin_row(m_row + 1);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_clear();
    else model_step(ppu_enable, vsync, rowram_swap, pmxr_done);
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (engine_start === 1'b1) es_count++;
    check("cycle_outputs",
          {19'd0, render_row, engine_start, row_ready, vram_sync_win, overrun, wdog_fired},
          {19'd0, RW'(m_row), m_start, m_ready, m_fdone, m_ovr, m_wd});
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; @(posedge clk); #1; vsync = 1'b0;
  endtask

  task automatic pulse_swap();
    rowram_swap = 1'b1; @(posedge clk); #1; rowram_swap = 1'b0;
  endtask

  task automatic pulse_done();
    pmxr_done = 1'b1; @(posedge clk); #1; pmxr_done = 1'b0;
  endtask

  // Called in the START cycle: done sampled d edges later, swap s edges later.
  task automatic run_row(input int d, input int s);
    wait_cycles(d - 1);
    pulse_done();
    wait_cycles(s - d - 1);
    pulse_swap();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int es0;
    int n;

    // Reset state
    wait_cycles(2);
    check("reset_row", render_row, 0);
    check("reset_flags", {engine_start, row_ready, vram_sync_win, overrun, wdog_fired}, 5'b00000);

    // Reset mid-RENDER
    rst_n = 1'b1; ppu_enable = 1'b1;
    pulse_vsync();
    check("first_start", engine_start, 1);
    check("first_row", render_row, 0);
    wait_cycles(5);
    check("in_render", {engine_start, row_ready}, 2'b00);
    rst_n = 1'b0;
    #2;
    check("async_reset_outs", {24'd0, render_row, engine_start, row_ready, vram_sync_win, overrun, wdog_fired}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(1);
    check("idle_after_reset", engine_start, 0);
    pulse_vsync();
    check("restart_start", engine_start, 1);
    check("restart_row", render_row, 0);
    wait_cycles(1);
    check("start_one_cycle", engine_start, 0);
    ppu_enable = 1'b0;
    wait_cycles(1);
    ppu_enable = 1'b1;

    // Normal frame
    es0 = es_count;
    pulse_vsync();
    for (int r = 0; r < NR; r++) begin
      check("frame_row", render_row, r);
      check("frame_start", engine_start, 1);
      run_row(40, 80);
    end
    check("frame_start_count", es_count - es0, NR);
    check("frame_end", {vram_sync_win, row_ready, overrun, wdog_fired}, 4'b1000);
    check("frame_last_row", render_row, NR - 1);

    // Frame 2: early swap on row 5, watchdog on row 10
    pulse_vsync();
    check("f2_no_overrun", overrun, 0);
    for (int r = 0; r < 5; r++) run_row(10, 20);
    check("f2_row5", render_row, 5);
    wait_cycles(4);
    pulse_swap();
    check("early_swap_ovr", {overrun, row_ready}, 2'b10);
    check("early_swap_row", render_row, 5);
    wait_cycles(4);
    pulse_done();
    check("row5_ready", row_ready, 1);
    pulse_done();
    wait_cycles(10);
    check("row5_held", {row_ready, engine_start}, 2'b10);
    check("row5_held_row", render_row, 5);
    pulse_swap();
    check("row6_start", engine_start, 1);
    check("row6_row", render_row, 6);
    run_row(10, 20);
    for (int r = 7; r < 10; r++) run_row(10, 20);
    check("row10", render_row, 10);
    n = 0;
    while (row_ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wdog_latency", n, WD);
    check("wdog_fired", wdog_fired, 1);
    pulse_swap();
    for (int r = 11; r < NR; r++) run_row(10, 20);
    check("f2_end", {vram_sync_win, overrun, wdog_fired}, 3'b111);
    pulse_swap();
    check("fdone_swap_ignored", {vram_sync_win, engine_start}, 2'b10);

    // Disable in FRAME_DONE clears flags; vsync with enable low is ignored
    ppu_enable = 1'b0;
    wait_cycles(1);
    check("disable_outs", {24'd0, render_row, engine_start, row_ready, vram_sync_win, overrun, wdog_fired}, 32'd0);
    pulse_vsync();
    check("disabled_vsync", engine_start, 0);
    wait_cycles(2);
    check("disabled_idle", {engine_start, row_ready}, 2'b00);

    // Frame 3: vsync with simultaneous swap in READY on row 100
    ppu_enable = 1'b1;
    pulse_vsync();
    for (int r = 0; r < 100; r++) run_row(10, 20);
    check("row100", render_row, 100);
    wait_cycles(9);
    pulse_done();
    check("row100_ready", row_ready, 1);
    check("row100_clean", overrun, 0);
    wait_cycles(3);
    vsync = 1'b1; rowram_swap = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0; rowram_swap = 1'b0;
    check("resync_ovr", overrun, 1);
    check("resync_row", render_row, 0);
    check("resync_start", engine_start, 1);

    // pmxr_done on the expiry cycle counts as done
    wait_cycles(WD - 1);
    pulse_done();
    check("expiry_done_ready", row_ready, 1);
    check("expiry_done_no_wdog", wdog_fired, 0);
    wait_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
